// File: rtl/mm_sequencer.sv
// mm_sequencer: control sequencer for a single-MAC matrix-vector product (out = W * in).
// Walks input/weight RAMs row by row, strobes the accumulator, writes each row result,
// and reports completion with an enable/done level handshake. No arithmetic datapath.
//
// Ports:
//   clk, reset (async, active-high), enable (level start request)
//   busy, done                       : run status
//   mem_rd_en, in_addr, w_addr       : RAM read strobe and addresses
//   mac_clear, mac_en, mac_last      : accumulator control, aligned to RAM read latency
//   out_we, out_addr                 : output buffer write of row j
//   act_valid, act_ready             : optional activation-stage handshake per row
//
// Optional feature: define MM_SEQ_ACT_EN to insert an ACT state between DRAIN and WRITE
// that offers each row to the activation stage and waits for act_ready. Without it,
// act_valid is tied low and act_ready is ignored.
module mm_sequencer #(
  parameter int INPUT_WIDTH  = 1152,
  parameter int OUTPUT_WIDTH = 128,
  parameter int MEM_LATENCY  = 1,
  parameter int AW_IN  = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1,
  parameter int AW_W   = (INPUT_WIDTH * OUTPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH * OUTPUT_WIDTH) : 1,
  parameter int AW_OUT = (OUTPUT_WIDTH > 1) ? $clog2(OUTPUT_WIDTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [AW_IN-1:0]  in_addr,
  output logic [AW_W-1:0]   w_addr,
  output logic              mac_clear,
  output logic              mac_en,
  output logic              mac_last,
  output logic              out_we,
  output logic [AW_OUT-1:0] out_addr,
  output logic              act_valid,
  input  logic              act_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MAC,
    S_DRAIN,
    S_ACT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [AW_IN-1:0]  LAST_I = AW_IN'(INPUT_WIDTH - 1);
  localparam logic [AW_OUT-1:0] LAST_J = AW_OUT'(OUTPUT_WIDTH - 1);
  localparam logic [AW_IN-1:0]  ONE_I  = AW_IN'(1);
  localparam logic [AW_W-1:0]   ONE_W  = AW_W'(1);
  localparam logic [AW_OUT-1:0] ONE_J  = AW_OUT'(1);

  state_t state;

  // Read strobe and "final read of the row" flag, delayed by the RAM latency so the
  // accumulate strobes line up with returning data.
  logic [MEM_LATENCY-1:0] rd_dly;
  logic [MEM_LATENCY-1:0] last_dly;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_dly   <= '0;
      last_dly <= '0;
    end else begin
      rd_dly[0]   <= mem_rd_en;
      last_dly[0] <= mem_rd_en && (in_addr == LAST_I);
      for (int k = 1; k < MEM_LATENCY; k++) begin
        rd_dly[k]   <= rd_dly[k-1];
        last_dly[k] <= last_dly[k-1];
      end
    end
  end

  assign mac_en   = rd_dly[MEM_LATENCY-1];
  assign mac_last = last_dly[MEM_LATENCY-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      in_addr   <= '0;
      w_addr    <= '0;
      mac_clear <= 1'b0;
      out_we    <= 1'b0;
      out_addr  <= '0;
`ifdef MM_SEQ_ACT_EN
      act_valid <= 1'b0;
`endif
    end else begin
      // Single-cycle strobes; only the state transition that needs them sets them.
      mac_clear <= 1'b0;
      out_we    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (enable) begin
            state     <= S_CLEAR;
            busy      <= 1'b1;
            mac_clear <= 1'b1;
            in_addr   <= '0;
            w_addr    <= '0;
            out_addr  <= '0;
          end
        end

        S_CLEAR: begin
          state     <= S_MAC;
          mem_rd_en <= 1'b1;
          in_addr   <= '0;
        end

        S_MAC: begin
          // w_addr is a running j*N+i counter: it carries across rows, so no multiply.
          w_addr <= w_addr + ONE_W;
          if (in_addr == LAST_I) begin
            state     <= S_DRAIN;
            mem_rd_en <= 1'b0;
            in_addr   <= '0;
          end else begin
            in_addr <= in_addr + ONE_I;
          end
        end

        S_DRAIN: begin
          // mac_last marks the cycle the row's final product is accumulated, which is
          // exactly the last of the MEM_LATENCY drain cycles.
          if (mac_last) begin
`ifdef MM_SEQ_ACT_EN
            state     <= S_ACT;
            act_valid <= 1'b1;
`else
            state     <= S_WRITE;
            out_we    <= 1'b1;
`endif
          end
        end

`ifdef MM_SEQ_ACT_EN
        S_ACT: begin
          if (act_ready) begin
            state     <= S_WRITE;
            act_valid <= 1'b0;
            out_we    <= 1'b1;
          end
        end
`endif

        S_WRITE: begin
          if (out_addr == LAST_J) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= S_CLEAR;
            out_addr  <= out_addr + ONE_J;
            mac_clear <= 1'b1;
          end
        end

        S_DONE: begin
          // Hold done while the requester keeps enable high; a low enable returns to IDLE.
          if (!enable) begin
            state    <= S_IDLE;
            done     <= 1'b0;
            out_addr <= '0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef MM_SEQ_ACT_EN
  assign act_valid = 1'b0;
  logic unused_act_ready;
  assign unused_act_ready = act_ready;
`endif

endmodule

// File: tb/tb_mm_sequencer.sv
// Bench for mm_sequencer: three instances (4x3 L1, 4x2 L3, 1x1 L1) checked against
// expected read/write/accumulate sequences queued when each run is started.
module tb_mm_sequencer;

`ifdef MM_SEQ_ACT_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk;
  logic [2:0] rst;
  logic [2:0] en;
  logic       act_ready;

  logic busy_a, done_a, rd_a, clr_a, mac_en_a, last_a, we_a, av_a;
  logic [1:0] in_a;
  logic [3:0] w_a;
  logic [1:0] oa_a;

  logic busy_b, done_b, rd_b, clr_b, mac_en_b, last_b, we_b, av_b;
  logic [1:0] in_b;
  logic [2:0] w_b;
  logic [0:0] oa_b;

  logic busy_c, done_c, rd_c, clr_c, mac_en_c, last_c, we_c, av_c;
  logic [0:0] in_c;
  logic [0:0] w_c;
  logic [0:0] oa_c;

  mm_sequencer #(.INPUT_WIDTH(4), .OUTPUT_WIDTH(3), .MEM_LATENCY(1)) dut_a (
    .clk(clk), .reset(rst[0]), .enable(en[0]), .busy(busy_a), .done(done_a),
    .mem_rd_en(rd_a), .in_addr(in_a), .w_addr(w_a), .mac_clear(clr_a), .mac_en(mac_en_a),
    .mac_last(last_a), .out_we(we_a), .out_addr(oa_a), .act_valid(av_a), .act_ready(act_ready)
  );

  mm_sequencer #(.INPUT_WIDTH(4), .OUTPUT_WIDTH(2), .MEM_LATENCY(3)) dut_b (
    .clk(clk), .reset(rst[1]), .enable(en[1]), .busy(busy_b), .done(done_b),
    .mem_rd_en(rd_b), .in_addr(in_b), .w_addr(w_b), .mac_clear(clr_b), .mac_en(mac_en_b),
    .mac_last(last_b), .out_we(we_b), .out_addr(oa_b), .act_valid(av_b), .act_ready(act_ready)
  );

  mm_sequencer #(.INPUT_WIDTH(1), .OUTPUT_WIDTH(1), .MEM_LATENCY(1)) dut_c (
    .clk(clk), .reset(rst[2]), .enable(en[2]), .busy(busy_c), .done(done_c),
    .mem_rd_en(rd_c), .in_addr(in_c), .w_addr(w_c), .mac_clear(clr_c), .mac_en(mac_en_c),
    .mac_last(last_c), .out_we(we_c), .out_addr(oa_c), .act_valid(av_c), .act_ready(act_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int NN[3] = '{4, 4, 1};
  int MM[3] = '{3, 2, 1};
  int LL[3] = '{1, 3, 1};

  typedef struct {
    logic busy, done, rd, clr, en, last, we, av;
    int   in_a, w_a, o_a;
  } obs_t;

  obs_t o[3];

  int vec_cnt = 0;
  int err_cnt = 0;

  int exp_in[3][$];
  int exp_w[3][$];
  int exp_oa[3][$];
  int exp_wec[3][$];
  int mac_cyc[3][$];
  int mac_lst[3][$];

  int busy_cnt[3];
  int last_cnt[3];
  int last_cyc[3];
  int done_rise[3];
  int start_cyc[3];
  logic prev_done[3];

  task automatic chk(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int any_out(input int d);
    return int'(o[d].busy | o[d].done | o[d].rd | o[d].clr | o[d].en | o[d].last |
                o[d].we | o[d].av) | o[d].in_a | o[d].w_a | o[d].o_a;
  endfunction

  function automatic int per_row(input int d);
    return NN[d] + LL[d] + 2 + EXTRA;
  endfunction

  // Monitor: sample all instances mid-cycle and pop/compare against queued expectations.
  always @(negedge clk) begin
    o[0] = '{busy_a, done_a, rd_a, clr_a, mac_en_a, last_a, we_a, av_a, int'(in_a), int'(w_a), int'(oa_a)};
    o[1] = '{busy_b, done_b, rd_b, clr_b, mac_en_b, last_b, we_b, av_b, int'(in_b), int'(w_b), int'(oa_b)};
    o[2] = '{busy_c, done_c, rd_c, clr_c, mac_en_c, last_c, we_c, av_c, int'(in_c), int'(w_c), int'(oa_c)};
    for (int d = 0; d < 3; d++) begin
      if (rst[d]) begin
        exp_in[d].delete(); exp_w[d].delete(); exp_oa[d].delete(); exp_wec[d].delete();
        mac_cyc[d].delete(); mac_lst[d].delete();
        prev_done[d] = 1'b0;
        continue;
      end
      if (o[d].busy) busy_cnt[d]++;
      if (o[d].done && !prev_done[d]) done_rise[d] = cyc;
      prev_done[d] = o[d].done;

      if (o[d].rd) begin
        if (exp_in[d].size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          chk("in_addr", o[d].in_a, exp_in[d].pop_front());
          chk("w_addr", o[d].w_a, exp_w[d].pop_front());
        end
        mac_cyc[d].push_back(cyc + LL[d]);
        mac_lst[d].push_back(int'(o[d].in_a == NN[d] - 1));
      end

      if (o[d].en) begin
        if (mac_cyc[d].size() == 0) chk("mac_en_unexpected", 1, 0);
        else begin
          chk("mac_en_cycle", cyc, mac_cyc[d].pop_front());
          chk("mac_last", o[d].last, mac_lst[d].pop_front());
        end
        if (o[d].last) begin
          last_cnt[d]++;
          last_cyc[d] = cyc;
        end
      end else begin
        if (o[d].last) chk("mac_last_without_en", 1, 0);
        if (mac_cyc[d].size() > 0 && mac_cyc[d][0] <= cyc) begin
          void'(mac_cyc[d].pop_front());
          void'(mac_lst[d].pop_front());
          chk("mac_en_missing", 0, 1);
        end
      end

      if (o[d].clr && o[d].en) chk("clear_with_mac_en", 1, 0);
      if (o[d].clr && !o[d].busy) chk("clear_not_busy", 1, 0);

      if (o[d].we) begin
        if (exp_oa[d].size() == 0) chk("we_unexpected", 1, 0);
        else begin
          int ec;
          chk("out_addr", o[d].o_a, exp_oa[d].pop_front());
          ec = exp_wec[d].pop_front();
          if (ec >= 0) chk("we_cycle", cyc, ec);
        end
`ifndef MM_SEQ_ACT_EN
        chk("we_after_last", cyc, last_cyc[d] + 1);
        if (o[d].av) chk("act_valid_tied", 1, 0);
`endif
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Start a run and queue every read, write and write cycle the run must produce.
  task automatic start_run(input int d);
    int s, p;
    rst[d] = 1'b0;
    en[d]  = 1'b1;
    s = cyc + 1;
    p = per_row(d);
    start_cyc[d] = s;
    busy_cnt[d]  = 0;
    last_cnt[d]  = 0;
    done_rise[d] = -1;
    for (int j = 0; j < MM[d]; j++) begin
      for (int i = 0; i < NN[d]; i++) begin
        exp_in[d].push_back(i);
        exp_w[d].push_back(j * NN[d] + i);
      end
      exp_oa[d].push_back(j);
`ifdef MM_SEQ_ACT_EN
      exp_wec[d].push_back(-1);
`else
      exp_wec[d].push_back(s + j * p + p - 1);
`endif
    end
  endtask

  task automatic finish_run(input int d, input bit chk_busy, input bit hold);
    int tot;
    tot = MM[d] * per_row(d);
    for (int t = 0; t < 400 && done_rise[d] < 0; t++) tick();
    if (done_rise[d] < 0) chk("done_timeout", 0, 1);
    if (chk_busy) begin
      chk("done_cycle", done_rise[d], start_cyc[d] + tot);
      chk("busy_cycles", busy_cnt[d], tot);
    end
    chk("mac_last_count", last_cnt[d], MM[d]);
    chk("reads_left", exp_in[d].size(), 0);
    chk("writes_left", exp_oa[d].size(), 0);
    if (hold) begin
      for (int t = 0; t < 5; t++) begin
        chk("done_hold", o[d].done, 1);
        if (t < 4) tick();
      end
      en[d] = 1'b0;
      tick();
      chk("idle_done", o[d].done, 0);
      chk("idle_busy", o[d].busy, 0);
      chk("idle_out_addr", o[d].o_a, 0);
    end else begin
      tick();
      chk("done_pulse", o[d].done, 0);
    end
  endtask

  initial begin
    rst = 3'b111;
    en  = 3'b000;
    act_ready = 1'b1;
    for (int d = 0; d < 3; d++) begin
      prev_done[d] = 1'b0;
      done_rise[d] = -1;
      last_cyc[d]  = -10;
    end
    tick();
    tick();
    for (int d = 0; d < 3; d++) chk("reset_outputs", any_out(d), 0);

    // Basic 4x3 run with enable held, then done handshake release.
    start_run(0);
    finish_run(0, 1'b1, 1'b1);

    // Second run (w_addr must restart at 0); enable dropped mid-run.
    start_run(0);
    tick(); tick(); tick();
    en[0] = 1'b0;
    finish_run(0, 1'b1, 1'b0);

    // Reset during row 1, i=2; outputs must clear without a clock edge.
    start_run(0);
    for (int t = 0; t < 100 && !(o[0].rd && o[0].o_a == 1 && o[0].in_a == 2); t++) tick();
    chk("reached_row1_i2", int'(o[0].rd && o[0].o_a == 1 && o[0].in_a == 2), 1);
    rst[0] = 1'b1;
    #1;
    chk("async_reset_outs", int'({busy_a, done_a, rd_a, clr_a, mac_en_a, last_a, we_a, av_a}), 0);
    chk("async_reset_addrs", int'({in_a, w_a, oa_a}), 0);
    tick();
    chk("reset_no_write", int'(we_a), 0);
    start_run(0);
    finish_run(0, 1'b1, 1'b1);

    // Latency alignment, 4x2 with L=3.
    start_run(1);
    finish_run(1, 1'b1, 1'b1);

    // Degenerate 1x1.
    start_run(2);
    finish_run(2, 1'b1, 1'b1);

`ifdef MM_SEQ_ACT_EN
    // Activation stall: act_ready low for the first 3 act_valid cycles of row 0.
    begin
      int oa0;
      act_ready = 1'b0;
      start_run(0);
      for (int t = 0; t < 100 && !o[0].av; t++) tick();
      chk("act_valid_seen", int'(o[0].av), 1);
      oa0 = o[0].o_a;
      for (int t = 0; t < 3; t++) begin
        chk("act_valid_hold", int'(o[0].av), 1);
        chk("act_out_addr_stable", o[0].o_a, oa0);
        chk("act_no_write", int'(o[0].we), 0);
        if (t < 2) tick();
      end
      act_ready = 1'b1;
      tick();
      chk("act_write", int'(o[0].we), 1);
      chk("act_valid_drop", int'(o[0].av), 0);
      finish_run(0, 1'b0, 1'b1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
